axis_rx_sample_fifo: RTL and testbench



---
 rtl/axis_rx_sample_fifo.sv | 138 +++++++++++++
 tb/tb_axis_rx_sample_fifo.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_rx_sample_fifo.sv
// RX sample FIFO between the DDC/decimator and the PS-side AXI-Stream reader.
// Optional saturating dropped-sample counter enabled by FIFO_DROP_COUNTER_EN.
module axis_rx_sample_fifo #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH      = 10,
  parameter int unsigned LEVEL_THRESHOLD = 512
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  clear_i,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [ADDR_WIDTH:0]   count_o,
  output logic                  overflow_o,
  output logic                  level_o
`ifdef FIFO_DROP_COUNTER_EN
  ,
  output logic [31:0]           drop_count_o
`endif
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned CW    = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] wptr, wptr_nxt;
  logic [ADDR_WIDTH-1:0] rptr, rptr_nxt;
  logic [CW-1:0]         count_nxt;
  logic [CW-1:0]         ram_cnt;
  logic [DATA_WIDTH-1:0] tdata_nxt;
  logic                  tvalid_nxt;
  logic                  overflow_nxt;
  logic                  level_nxt;
  logic                  full;
  logic                  wr_en;
  logic                  drop;
  logic                  rd_hs;
  logic                  load;

  // Full is judged on the registered count, so a same-cycle read never admits a write at full.
  always_comb begin
    full    = (count_o == CW'(DEPTH));
    wr_en   = s_axis_tvalid && !full && !clear_i;
    drop    = s_axis_tvalid && full && !clear_i;
    rd_hs   = m_axis_tvalid && m_axis_tready;
    ram_cnt = count_o - CW'(m_axis_tvalid);
    load    = (ram_cnt != '0) && (!m_axis_tvalid || rd_hs);
  end

  // Next-state for pointers, output word, count and flags.
  always_comb begin
    wptr_nxt     = wptr;
    rptr_nxt     = rptr;
    tdata_nxt    = m_axis_tdata;
    tvalid_nxt   = m_axis_tvalid;
    count_nxt    = count_o;
    overflow_nxt = overflow_o;
    level_nxt    = level_o;
    if (clear_i) begin
      wptr_nxt     = '0;
      rptr_nxt     = '0;
      tvalid_nxt   = 1'b0;
      count_nxt    = '0;
      overflow_nxt = 1'b0;
      level_nxt    = 1'b0;
    end else begin
      if (wr_en) begin
        wptr_nxt = wptr + ADDR_WIDTH'(1);
      end
      if (load) begin
        rptr_nxt   = rptr + ADDR_WIDTH'(1);
        tdata_nxt  = mem[rptr];
        tvalid_nxt = 1'b1;
      end else if (rd_hs) begin
        tvalid_nxt = 1'b0;
      end
      count_nxt    = count_o + CW'(wr_en) - CW'(rd_hs);
      overflow_nxt = overflow_o | drop;
      level_nxt    = 32'(count_nxt) >= 32'(LEVEL_THRESHOLD);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      s_axis_tready <= 1'b0;
      wptr          <= '0;
      rptr          <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      count_o       <= '0;
      overflow_o    <= 1'b0;
      level_o       <= 1'b0;
    end else begin
      s_axis_tready <= 1'b1;
      wptr          <= wptr_nxt;
      rptr          <= rptr_nxt;
      m_axis_tdata  <= tdata_nxt;
      m_axis_tvalid <= tvalid_nxt;
      count_o       <= count_nxt;
      overflow_o    <= overflow_nxt;
      level_o       <= level_nxt;
    end
  end

  // Sample storage; contents survive clear_i and reset.
  always_ff @(posedge aclk) begin
    if (wr_en) begin
      mem[wptr] <= s_axis_tdata;
    end
  end

`ifdef FIFO_DROP_COUNTER_EN
  logic [31:0] drop_count_nxt;

  always_comb begin
    drop_count_nxt = drop_count_o;
    if (clear_i) begin
      drop_count_nxt = '0;
    end else if (drop && (drop_count_o != 32'hFFFF_FFFF)) begin
      drop_count_nxt = drop_count_o + 32'd1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      drop_count_o <= '0;
    end else begin
      drop_count_o <= drop_count_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_axis_rx_sample_fifo.sv
// Directed bench for axis_rx_sample_fifo with DEPTH=16 and LEVEL_THRESHOLD=8.
module tb_axis_rx_sample_fifo;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned LT    = 8;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic          clear_i;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [AW:0]   count_o;
  logic          overflow_o;
  logic          level_o;
  logic [31:0]   drop_count_o;

  int checks = 0;
  int errors = 0;

  always #5 aclk = ~aclk;

  axis_rx_sample_fifo #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .LEVEL_THRESHOLD(LT)
  ) dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .clear_i(clear_i),
    .s_axis_tdata(s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .count_o(count_o),
    .overflow_o(overflow_o),
    .level_o(level_o)
`ifdef FIFO_DROP_COUNTER_EN
    ,
    .drop_count_o(drop_count_o)
`endif
  );

`ifndef FIFO_DROP_COUNTER_EN
  assign drop_count_o = '0;
`endif

  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  task automatic do_clear;
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
  endtask

  task automatic test_reset;
    aresetn = 1'b0; clear_i = 1'b0; s_axis_tvalid = 1'b0; s_axis_tdata = '0; m_axis_tready = 1'b0;
    #12;
    checks++; if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL reset_tready got %0b exp 0", s_axis_tready); end
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %0b exp 0", m_axis_tvalid); end
    checks++; if (m_axis_tdata !== 32'h0) begin errors++; $display("FAIL reset_tdata got %0h exp 0", m_axis_tdata); end
    checks++; if (count_o !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count_o); end
    checks++; if ({overflow_o, level_o} !== 2'b00) begin errors++; $display("FAIL reset_flags got %0b exp 00", {overflow_o, level_o}); end
    aresetn = 1'b1;
    tick();
    checks++; if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL release_tready got %0b exp 1", s_axis_tready); end
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL release_tvalid got %0b exp 0", m_axis_tvalid); end
  endtask

  task automatic test_fwft_hold;
    logic [DW-1:0] vals [3];
    vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_axis_tdata = vals[i];
      tick();
      checks++; if (m_axis_tvalid !== (i > 0)) begin errors++; $display("FAIL fwft_valid%0d got %0b exp %0b", i, m_axis_tvalid, (i > 0)); end
      checks++; if (count_o !== 5'(i + 1)) begin errors++; $display("FAIL fwft_count%0d got %0d exp %0d", i, count_o, i + 1); end
    end
    s_axis_tvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (m_axis_tdata !== 32'h11) begin errors++; $display("FAIL fwft_hold%0d got %0h exp 11", i, m_axis_tdata); end
      tick();
    end
    checks++; if (count_o !== 5'd3) begin errors++; $display("FAIL fwft_count_hold got %0d exp 3", count_o); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (m_axis_tdata !== vals[i]) begin errors++; $display("FAIL fwft_drain%0d got %0h exp %0h", i, m_axis_tdata, vals[i]); end
      m_axis_tready = 1'b1;
      tick();
    end
    m_axis_tready = 1'b0;
    checks++; if ({m_axis_tvalid, count_o} !== 6'd0) begin errors++; $display("FAIL fwft_empty got v=%0b c=%0d exp 0/0", m_axis_tvalid, count_o); end
  endtask

  task automatic test_drain_order;
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s_axis_tdata = 32'hA0 + 32'(i);
      tick();
    end
    s_axis_tvalid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++; if (count_o !== 5'(8 - i)) begin errors++; $display("FAIL drain_count%0d got %0d exp %0d", i, count_o, 8 - i); end
      checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'hA0 + 32'(i)) begin errors++; $display("FAIL drain_data%0d got v=%0b d=%0h exp v=1 d=%0h", i, m_axis_tvalid, m_axis_tdata, 32'hA0 + 32'(i)); end
      m_axis_tready = 1'b1;
      tick();
    end
    m_axis_tready = 1'b0;
    checks++; if ({m_axis_tvalid, count_o} !== 6'd0) begin errors++; $display("FAIL drain_empty got v=%0b c=%0d exp 0/0", m_axis_tvalid, count_o); end
  endtask

  task automatic test_overflow;
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      s_axis_tdata = 32'(i);
      tick();
    end
    s_axis_tvalid = 1'b0;
    checks++; if (count_o !== 5'd16) begin errors++; $display("FAIL ovf_count got %0d exp 16", count_o); end
    checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_flag got %0b exp 1", overflow_o); end
`ifdef FIFO_DROP_COUNTER_EN
    checks++; if (drop_count_o !== 32'd4) begin errors++; $display("FAIL ovf_drop_count got %0d exp 4", drop_count_o); end
`endif
    for (int i = 0; i < 16; i++) begin
      checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'(i)) begin errors++; $display("FAIL ovf_data%0d got v=%0b d=%0h exp v=1 d=%0h", i, m_axis_tvalid, m_axis_tdata, i); end
      m_axis_tready = 1'b1;
      tick();
    end
    m_axis_tready = 1'b0;
    checks++; if ({m_axis_tvalid, count_o, overflow_o} !== 7'b0000001) begin errors++; $display("FAIL ovf_after_drain got v=%0b c=%0d o=%0b exp 0/0/1", m_axis_tvalid, count_o, overflow_o); end
    do_clear();
    checks++; if (overflow_o !== 1'b0 || drop_count_o !== 32'd0) begin errors++; $display("FAIL ovf_clear got o=%0b dc=%0d exp 0/0", overflow_o, drop_count_o); end
  endtask

  task automatic test_full_read_drop;
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      s_axis_tdata = 32'h100 + 32'(i);
      tick();
    end
    checks++; if (count_o !== 5'd16 || overflow_o !== 1'b0) begin errors++; $display("FAIL full_exact got c=%0d o=%0b exp 16/0", count_o, overflow_o); end
    s_axis_tdata = 32'hDEAD;
    m_axis_tready = 1'b1;
    tick();
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;
    checks++; if (count_o !== 5'd15 || overflow_o !== 1'b1) begin errors++; $display("FAIL full_rd_drop got c=%0d o=%0b exp 15/1", count_o, overflow_o); end
`ifdef FIFO_DROP_COUNTER_EN
    checks++; if (drop_count_o !== 32'd1) begin errors++; $display("FAIL full_rd_drop_count got %0d exp 1", drop_count_o); end
`endif
    for (int i = 1; i < 16; i++) begin
      checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'h100 + 32'(i)) begin errors++; $display("FAIL full_rd_data%0d got v=%0b d=%0h exp v=1 d=%0h", i, m_axis_tvalid, m_axis_tdata, 32'h100 + 32'(i)); end
      m_axis_tready = 1'b1;
      tick();
    end
    m_axis_tready = 1'b0;
    checks++; if ({m_axis_tvalid, count_o} !== 6'd0) begin errors++; $display("FAIL full_rd_empty got v=%0b c=%0d exp 0/0", m_axis_tvalid, count_o); end
    do_clear();
  endtask

  task automatic test_back_to_back;
    int n;
    n = 3 * DEPTH;
    m_axis_tready = 1'b1;
    s_axis_tvalid = 1'b1;
    for (int k = 0; k < n; k++) begin
      s_axis_tdata = 32'h1000 + 32'(k);
      tick();
      checks++; if (count_o !== ((k == 0) ? 5'd1 : 5'd2)) begin errors++; $display("FAIL b2b_count%0d got %0d exp %0d", k, count_o, (k == 0) ? 1 : 2); end
      if (k > 0) begin
        checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'h1000 + 32'(k - 1)) begin errors++; $display("FAIL b2b_data%0d got v=%0b d=%0h exp v=1 d=%0h", k, m_axis_tvalid, m_axis_tdata, 32'h1000 + 32'(k - 1)); end
      end
    end
    s_axis_tvalid = 1'b0;
    tick();
    checks++; if (count_o !== 5'd1 || m_axis_tdata !== 32'h1000 + 32'(n - 1)) begin errors++; $display("FAIL b2b_tail got c=%0d d=%0h exp 1/%0h", count_o, m_axis_tdata, 32'h1000 + 32'(n - 1)); end
    tick();
    m_axis_tready = 1'b0;
    checks++; if ({m_axis_tvalid, count_o, overflow_o} !== 7'd0) begin errors++; $display("FAIL b2b_end got v=%0b c=%0d o=%0b exp 0/0/0", m_axis_tvalid, count_o, overflow_o); end
  endtask

  task automatic test_level;
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s_axis_tdata = 32'h200 + 32'(i);
      tick();
      checks++; if (level_o !== (i + 1 >= LT)) begin errors++; $display("FAIL level_up%0d got %0b exp %0b", i, level_o, (i + 1 >= LT)); end
    end
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    tick();
    m_axis_tready = 1'b0;
    checks++; if (level_o !== 1'b0 || count_o !== 5'd7) begin errors++; $display("FAIL level_down got l=%0b c=%0d exp 0/7", level_o, count_o); end
    do_clear();
  endtask

  task automatic test_clear;
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_axis_tdata = 32'h300 + 32'(i);
      tick();
    end
    checks++; if (count_o !== 5'd5) begin errors++; $display("FAIL clear_pre got %0d exp 5", count_o); end
    s_axis_tdata = 32'hBAD;
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    s_axis_tvalid = 1'b0;
    checks++; if ({m_axis_tvalid, count_o, overflow_o, level_o} !== 8'd0) begin errors++; $display("FAIL clear_state got v=%0b c=%0d o=%0b l=%0b exp all 0", m_axis_tvalid, count_o, overflow_o, level_o); end
    tick();
    tick();
    checks++; if ({m_axis_tvalid, count_o} !== 6'd0) begin errors++; $display("FAIL clear_discard got v=%0b c=%0d exp 0/0", m_axis_tvalid, count_o); end
  endtask

  task automatic test_async_reset;
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_axis_tdata = 32'h400 + 32'(i);
      tick();
    end
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    tick();
    #2;
    aresetn = 1'b0;
    #1;
    checks++; if ({s_axis_tready, m_axis_tvalid, count_o, overflow_o, level_o} !== 9'd0) begin errors++; $display("FAIL arst_state got r=%0b v=%0b c=%0d o=%0b l=%0b exp all 0", s_axis_tready, m_axis_tvalid, count_o, overflow_o, level_o); end
    checks++; if (m_axis_tdata !== 32'h0) begin errors++; $display("FAIL arst_tdata got %0h exp 0", m_axis_tdata); end
    #8;
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL arst_hold_valid got %0b exp 0", m_axis_tvalid); end
    aresetn = 1'b1;
    tick();
    checks++; if ({s_axis_tready, m_axis_tvalid, count_o} !== 7'b1000000) begin errors++; $display("FAIL arst_release got r=%0b v=%0b c=%0d exp 1/0/0", s_axis_tready, m_axis_tvalid, count_o); end
    m_axis_tready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fwft_hold();
    test_drain_order();
    test_overflow();
    test_full_read_drop();
    test_back_to_back();
    test_level();
    test_clear();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
